// File: rtl/core_data_mem_responder_pkg.sv
// Shared types and constants for the core data port responder.
//
// Contents:
//   core_data_req_t    request from the core / TCDM-style master
//   core_data_rsp_t    response back to the master (gnt, r_valid, r_data)
//   core_data_meta_t   per-transaction bookkeeping kept while a request is in flight
//   CoreDataErrRspData default read data for requests answered without memory
//   core_data_in_range address window test used by the optional range check
package core_data_mem_responder_pkg;

    typedef struct packed {
        logic        req;
        logic [31:0] add;
        logic        we;
        logic [31:0] data;
        logic [3:0]  be;
    } core_data_req_t;

    typedef struct packed {
        logic        gnt;
        logic        r_valid;
        logic [31:0] r_data;
    } core_data_rsp_t;

    // is_local: answered by the responder itself, no memory access was made.
    typedef struct packed {
        logic is_local;
        logic we;
    } core_data_meta_t;

    localparam logic [31:0] CoreDataErrRspData = 32'hBADA_CCE5;

    // Evaluated on 33 bits so a window that ends exactly at 2^32 does not wrap.
    function automatic logic core_data_in_range(input logic [31:0] addr,
                                                input logic [31:0] base,
                                                input logic [31:0] size);
        logic [32:0] a;
        logic [32:0] lo;
        logic [32:0] hi;
        a  = {1'b0, addr};
        lo = {1'b0, base};
        hi = lo + {1'b0, size};
        return (a >= lo) && (a < hi);
    endfunction

endpackage

// File: rtl/core_data_mem_responder_rsp_fifo.sv
// core_data_rsp_fifo: generic synchronous FIFO used for the in-flight
// transaction metadata and for read data returned by the memory.
//
// Parameters: T (entry type), Depth (entries, power of two, >= 2).
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset (empties the FIFO)
//   push_i, data_i      write an entry (ignored when full and not popping)
//   pop_i               remove the head entry (ignored when empty)
//   data_o              head entry, valid while empty_o is low
//   full_o, empty_o     occupancy flags
//   count_o             number of stored entries
module core_data_rsp_fifo #(
    parameter type         T     = logic [31:0],
    parameter int unsigned Depth = 4,
    localparam int unsigned PtrW = $clog2(Depth),
    localparam int unsigned CntW = PtrW + 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            push_i,
    input  T                data_i,
    input  logic            pop_i,
    output T                data_o,
    output logic            full_o,
    output logic            empty_o,
    output logic [CntW-1:0] count_o
);

    T                mem_q [Depth];
    T                mem_d [Depth];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            do_push;
    logic            do_pop;

    assign full_o  = (count_q == CntW'(Depth));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    // A pop frees the slot in the same cycle, so a full FIFO may push while popping.
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_comb begin
        // NOTE: every always_comb output is given a default first so no path leaves it unassigned (no latch).
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + CntW'(do_push) - CntW'(do_pop);
        if (do_push) begin
            mem_d[wr_ptr_q] = data_i;
            wr_ptr_d        = wr_ptr_q + PtrW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is not reset; an entry is only read after it was written, so clearing pointers is enough.
    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/core_data_mem_responder.sv
// core_data_mem_responder: responder end of the cluster core data port.
// Bridges a core/TCDM-style master to an in-order, variable-latency memory
// with at most MaxOutstanding granted-but-unanswered transactions. Every
// granted request, read or write, receives exactly one r_valid in grant order.
//
// Optional feature (macro CORE_DATA_RSP_ERR_EN): addresses outside
// [MemBaseAddr, MemBaseAddr+MemSize) are answered locally with ErrRspData
// and err_o=1 without touching memory; err_o only exists with the macro.
//
// Ports:
//   clk_i, rst_i       clock, synchronous active-high reset
//   req_i / rsp_o      core data request / response
//   mem_req_o..be_o    memory request channel (address rebased to MemBaseAddr)
//   mem_gnt_i          memory accepts the current request
//   mem_rvalid_i/rdata one in-order response per granted memory request
//   outstanding_o      granted, not yet answered transactions
//   err_o              error flag, valid with rsp_o.r_valid (macro only)
module core_data_mem_responder
    import core_data_mem_responder_pkg::*;
#(
    parameter int unsigned AddrWidth      = 32,
    parameter logic [31:0] MemBaseAddr    = 32'h1000_0000,
    parameter int unsigned MemSize        = 64 * 1024,
    parameter int unsigned MaxOutstanding = 4,
    parameter logic [31:0] ErrRspData     = CoreDataErrRspData,
    localparam int unsigned CntW          = $clog2(MaxOutstanding) + 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  core_data_req_t       req_i,
    output core_data_rsp_t       rsp_o,
    output logic                 mem_req_o,
    input  logic                 mem_gnt_i,
    output logic                 mem_we_o,
    output logic [AddrWidth-1:0] mem_addr_o,
    output logic [31:0]          mem_wdata_o,
    output logic [3:0]           mem_be_o,
    input  logic                 mem_rvalid_i,
    input  logic [31:0]          mem_rdata_i,
    output logic [CntW-1:0]      outstanding_o
`ifdef CORE_DATA_RSP_ERR_EN
    ,
    output logic                 err_o
`endif
);

`ifdef CORE_DATA_RSP_ERR_EN
    typedef core_data_meta_t meta_t;
`else
    // Without local answers the only thing worth remembering is the direction.
    typedef logic meta_t;
`endif

    logic            is_local;
    logic            full;
    logic            gnt;
    logic [31:0]     addr_offset;

    meta_t           meta_push_data;
    meta_t           meta_head;
    logic            meta_empty;
    logic            meta_pop;
    logic [CntW-1:0] meta_count;

    logic            rdata_push;
    logic            rdata_pop;
    logic            rdata_empty;
    logic [31:0]     rdata_head;
    logic            rdata_full_unused;
    logic [CntW-1:0] rdata_count_unused;

    logic            head_is_local;

    logic            r_valid_q, r_valid_d;
    logic [31:0]     r_data_q,  r_data_d;
`ifdef CORE_DATA_RSP_ERR_EN
    logic            err_q,     err_d;
`endif

    // ------------------------------------------------------------------
    // Request side
    // ------------------------------------------------------------------
`ifdef CORE_DATA_RSP_ERR_EN
    assign is_local       = ~core_data_in_range(req_i.add, MemBaseAddr, 32'(MemSize));
    assign meta_push_data = '{is_local: is_local, we: req_i.we};
    assign head_is_local  = meta_head.is_local;

    logic unused_meta_we;
    assign unused_meta_we = meta_head.we;
`else
    assign is_local       = 1'b0;
    assign meta_push_data = req_i.we;
    assign head_is_local  = 1'b0;

    logic        unused_meta_we;
    logic [31:0] unused_params;
    assign unused_meta_we = meta_head;
    assign unused_params  = ErrRspData ^ 32'(MemSize);
`endif

    // The credit freed by a pop only becomes visible the following cycle.
    assign outstanding_o = meta_count;

    assign mem_req_o = req_i.req & ~is_local & ~full;
    assign gnt       = is_local ? (req_i.req & ~full) : (mem_req_o & mem_gnt_i);

    assign addr_offset = req_i.add - MemBaseAddr;
    assign mem_addr_o  = addr_offset[AddrWidth-1:0];
    assign mem_we_o    = req_i.we;
    assign mem_wdata_o = req_i.data;
    assign mem_be_o    = req_i.be;

    core_data_rsp_fifo #(
        .T     (meta_t),
        .Depth (MaxOutstanding)
    ) u_meta_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (gnt),
        .data_i  (meta_push_data),
        .pop_i   (meta_pop),
        .data_o  (meta_head),
        .full_o  (full),
        .empty_o (meta_empty),
        .count_o (meta_count)
    );

    // ------------------------------------------------------------------
    // Memory response side
    // ------------------------------------------------------------------
    // A response with nothing in flight is a leftover from before a reset.
    // Otherwise it always has a slot: memory transactions never exceed meta entries.
    assign rdata_push = mem_rvalid_i & ~meta_empty;

    core_data_rsp_fifo #(
        .T     (logic [31:0]),
        .Depth (MaxOutstanding)
    ) u_rdata_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (rdata_push),
        .data_i  (mem_rdata_i),
        .pop_i   (rdata_pop),
        .data_o  (rdata_head),
        .full_o  (rdata_full_unused),
        .empty_o (rdata_empty),
        .count_o (rdata_count_unused)
    );

    // ------------------------------------------------------------------
    // Output stage: answer the head transaction as soon as it can be answered.
    // A local head never waits for memory; a memory head blocks everything behind it.
    // ------------------------------------------------------------------
    always_comb begin
        meta_pop  = 1'b0;
        rdata_pop = 1'b0;
        r_valid_d = 1'b0;
        r_data_d  = r_data_q;
`ifdef CORE_DATA_RSP_ERR_EN
        err_d     = 1'b0;
`endif
        if (!meta_empty) begin
            if (head_is_local) begin
                meta_pop  = 1'b1;
                r_valid_d = 1'b1;
                r_data_d  = ErrRspData;
`ifdef CORE_DATA_RSP_ERR_EN
                err_d     = 1'b1;
`endif
            end else if (!rdata_empty) begin
                meta_pop  = 1'b1;
                rdata_pop = 1'b1;
                r_valid_d = 1'b1;
                r_data_d  = rdata_head;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_valid_q <= 1'b0;
            r_data_q  <= '0;
`ifdef CORE_DATA_RSP_ERR_EN
            err_q     <= 1'b0;
`endif
        end else begin
            r_valid_q <= r_valid_d;
            r_data_q  <= r_data_d;
`ifdef CORE_DATA_RSP_ERR_EN
            err_q     <= err_d;
`endif
        end
    end

    assign rsp_o = '{gnt: gnt, r_valid: r_valid_q, r_data: r_data_q};
`ifdef CORE_DATA_RSP_ERR_EN
    assign err_o = err_q;
`endif

endmodule

// File: tb/tb_core_data_mem_responder.sv
// Directed bench for core_data_mem_responder. Expected responses are queued
// as stimulus is issued; a monitor pops and compares on every r_valid.
module tb_core_data_mem_responder;
    import core_data_mem_responder_pkg::*;

    logic           clk_i = 1'b0;
    logic           rst_i;
    core_data_req_t req_i;
    core_data_rsp_t rsp_o;
    logic           mem_req_o;
    logic           mem_gnt_i;
    logic           mem_we_o;
    logic [31:0]    mem_addr_o;
    logic [31:0]    mem_wdata_o;
    logic [3:0]     mem_be_o;
    logic           mem_rvalid_i;
    logic [31:0]    mem_rdata_i;
    logic [2:0]     outstanding_o;
`ifdef CORE_DATA_RSP_ERR_EN
    logic           err_o;
`endif

    always #5 clk_i = ~clk_i;

    core_data_mem_responder dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .req_i         (req_i),
        .rsp_o         (rsp_o),
        .mem_req_o     (mem_req_o),
        .mem_gnt_i     (mem_gnt_i),
        .mem_we_o      (mem_we_o),
        .mem_addr_o    (mem_addr_o),
        .mem_wdata_o   (mem_wdata_o),
        .mem_be_o      (mem_be_o),
        .mem_rvalid_i  (mem_rvalid_i),
        .mem_rdata_i   (mem_rdata_i),
        .outstanding_o (outstanding_o)
`ifdef CORE_DATA_RSP_ERR_EN
        ,
        .err_o         (err_o)
`endif
    );

    typedef struct {
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   rsp_seen = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs sampled on the falling edge.
    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk_i);
    endtask

    task automatic idle();
        req_i        = '0;
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = '0;
    endtask

    task automatic drive_read(input logic [31:0] addr);
        req_i      = '0;
        req_i.req  = 1'b1;
        req_i.add  = addr;
        req_i.be   = 4'hF;
    endtask

    task automatic mem_respond(input logic [31:0] data);
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = data;
    endtask

    function automatic exp_t mk_exp(input logic [31:0] d, input logic e);
        exp_t x;
        x.data = d;
        x.err  = e;
        return x;
    endfunction

    // Scoreboard monitor
    always @(negedge clk_i) begin
        if (rsp_o.r_valid === 1'b1) begin
            rsp_seen++;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_rsp: got r_data 0x%0h, required no response", rsp_o.r_data);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("rsp_data", 64'(rsp_o.r_data), 64'(e.data));
`ifdef CORE_DATA_RSP_ERR_EN
                check("rsp_err", 64'(err_o), 64'(e.err));
`endif
            end
        end
    end

    initial begin
        int seen_before;

        // ---------------- reset ----------------
        rst_i = 1'b1;
        idle();
        cyc();
        cyc();
        at_neg();
        check("rst_rsp", 64'(rsp_o), 64'(0));
        check("rst_mem_req", 64'(mem_req_o), 64'(0));
        check("rst_outstanding", 64'(outstanding_o), 64'(0));
`ifdef CORE_DATA_RSP_ERR_EN
        check("rst_err", 64'(err_o), 64'(0));
`endif
        cyc();
        rst_i = 1'b0;
        cyc();

        // ---------------- single read, latency ----------------
        drive_read(32'h1000_0010);
        mem_gnt_i = 1'b1;
        exp_q.push_back(mk_exp(32'h1234_5678, 1'b0));
        at_neg();
        check("rd_addr", 64'(mem_addr_o), 64'h10);
        check("rd_gnt", 64'(rsp_o.gnt), 64'(1));
        check("rd_we", 64'(mem_we_o), 64'(0));
        cyc();                                    // t1
        idle();
        mem_respond(32'h1234_5678);
        at_neg();
        check("rd_out_t1", 64'(outstanding_o), 64'(1));
        check("rd_rvalid_t1", 64'(rsp_o.r_valid), 64'(0));
        cyc();                                    // t2
        idle();
        at_neg();
        check("rd_out_t2", 64'(outstanding_o), 64'(1));
        check("rd_rvalid_t2", 64'(rsp_o.r_valid), 64'(0));
        cyc();                                    // t3
        at_neg();
        check("rd_rvalid_t3", 64'(rsp_o.r_valid), 64'(1));
        check("rd_out_t3", 64'(outstanding_o), 64'(0));
        cyc();

        // ---------------- write pass-through, one response ----------------
        seen_before = rsp_seen;
        req_i      = '0;
        req_i.req  = 1'b1;
        req_i.we   = 1'b1;
        req_i.add  = 32'h1000_0004;
        req_i.be   = 4'b0011;
        req_i.data = 32'hCAFE_F00D;
        mem_gnt_i  = 1'b1;
        exp_q.push_back(mk_exp(32'hDEAD_0001, 1'b0));
        at_neg();
        check("wr_we", 64'(mem_we_o), 64'(1));
        check("wr_be", 64'(mem_be_o), 64'h3);
        check("wr_wdata", 64'(mem_wdata_o), 64'hCAFE_F00D);
        check("wr_addr", 64'(mem_addr_o), 64'h4);
        check("wr_gnt", 64'(rsp_o.gnt), 64'(1));
        cyc();
        idle();
        mem_respond(32'hDEAD_0001);
        cyc();
        idle();
        repeat (4) cyc();
        check("wr_one_rsp", 64'(rsp_seen - seen_before), 64'(1));

        // ---------------- memory stalls grant ----------------
        drive_read(32'h1000_0020);
        mem_gnt_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            at_neg();
            check("stall_gnt", 64'(rsp_o.gnt), 64'(0));
            check("stall_out", 64'(outstanding_o), 64'(0));
            check("stall_mem_req", 64'(mem_req_o), 64'(1));
            cyc();
        end
        mem_gnt_i = 1'b1;
        exp_q.push_back(mk_exp(32'h0000_0033, 1'b0));
        at_neg();
        check("stall_gnt4", 64'(rsp_o.gnt), 64'(1));
        cyc();
        idle();
        mem_respond(32'h0000_0033);
        cyc();
        idle();
        repeat (3) cyc();

        // ---------------- outstanding limit ----------------
        for (int i = 0; i < 4; i++) begin
            drive_read(32'h1000_0100 + 32'(4 * i));
            mem_gnt_i = 1'b1;
            exp_q.push_back(mk_exp(32'hA000_0000 + 32'(i), 1'b0));
            at_neg();
            check("lim_gnt", 64'(rsp_o.gnt), 64'(1));
            cyc();
        end
        drive_read(32'h1000_0200);
        mem_gnt_i = 1'b1;
        at_neg();
        check("lim_full_gnt", 64'(rsp_o.gnt), 64'(0));
        check("lim_full_mem_req", 64'(mem_req_o), 64'(0));
        check("lim_full_out", 64'(outstanding_o), 64'(4));
        cyc();
        mem_respond(32'hA000_0000);
        at_neg();
        check("lim_gnt_rv", 64'(rsp_o.gnt), 64'(0));
        cyc();
        mem_rvalid_i = 1'b0;
        at_neg();
        check("lim_gnt_pop", 64'(rsp_o.gnt), 64'(0));
        check("lim_out_pop", 64'(outstanding_o), 64'(4));
        cyc();
        at_neg();
        check("lim_gnt_after", 64'(rsp_o.gnt), 64'(1));
        check("lim_out_after", 64'(outstanding_o), 64'(3));
        exp_q.push_back(mk_exp(32'hA000_0004, 1'b0));
        cyc();
        idle();
        for (int i = 1; i < 5; i++) begin
            mem_respond(32'hA000_0000 + 32'(i));
            cyc();
        end
        idle();
        repeat (4) cyc();

`ifdef CORE_DATA_RSP_ERR_EN
        // ---------------- local error answer behind a memory read ----------------
        drive_read(32'h1000_0040);
        mem_gnt_i = 1'b1;
        exp_q.push_back(mk_exp(32'h0000_0055, 1'b0));
        at_neg();
        check("err_inrange_mem_req", 64'(mem_req_o), 64'(1));
        cyc();
        drive_read(32'h2000_0000);
        mem_gnt_i = 1'b0;
        exp_q.push_back(mk_exp(32'hBADA_CCE5, 1'b1));
        at_neg();
        check("err_local_gnt", 64'(rsp_o.gnt), 64'(1));
        check("err_local_mem_req", 64'(mem_req_o), 64'(0));
        cyc();
        idle();
        repeat (3) cyc();
        mem_respond(32'h0000_0055);
        cyc();
        idle();
        at_neg();
        check("err_order_wait", 64'(rsp_o.r_valid), 64'(0));
        cyc();
        at_neg();
        check("err_mem_first", 64'(rsp_o.r_data), 64'h55);
        cyc();
        at_neg();
        check("err_local_next", 64'(rsp_o.r_data), 64'hBADA_CCE5);
        cyc();
        repeat (2) cyc();
`endif

        // ---------------- reset mid-operation ----------------
        seen_before = rsp_seen;
        for (int i = 0; i < 3; i++) begin
            drive_read(32'h1000_0300 + 32'(4 * i));
            mem_gnt_i = 1'b1;
            cyc();
        end
        idle();
        at_neg();
        check("mid_out_before", 64'(outstanding_o), 64'(3));
        rst_i = 1'b1;
        cyc();
        rst_i = 1'b0;
        at_neg();
        check("mid_out_rst", 64'(outstanding_o), 64'(0));
        check("mid_rvalid_rst", 64'(rsp_o.r_valid), 64'(0));
        cyc();
        mem_respond(32'hDEAD_BEEF);
        cyc();
        mem_respond(32'hDEAD_BEE0);
        cyc();
        idle();
        repeat (4) cyc();
        check("mid_no_rsp", 64'(rsp_seen - seen_before), 64'(0));
        check("mid_out_end", 64'(outstanding_o), 64'(0));

        // ---------------- drain scoreboard (bounded) ----------------
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) cyc();
        check("scoreboard_drained", 64'(exp_q.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
